// File: rtl/jt900h_fetch.sv
// ============================================================================
// jt900h_fetch : instruction prefetch byte queue with 4-byte window at PC.
// Optional macro JT900H_FETCH_STATS_EN adds the stall_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module jt900h_fetch #(
  parameter int          QBYTES = 8,
  parameter logic [23:0] RST_PC = 24'hFF0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        pc_ld,
  input  logic [23:0] pc_din,
  input  logic        inc_pc,
  input  logic [1:0]  fetch_sel,
  output logic [31:0] md,
  output logic        mem_busy,
  output logic [23:0] pc,
  output logic [22:0] bus_addr,
  output logic        bus_rd,
  input  logic        bus_ok,
  input  logic [15:0] bus_din
`ifdef JT900H_FETCH_STATS_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  localparam int AW = $clog2(QBYTES);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      queue [QBYTES];
  logic [AW-1:0]   head;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count, count_nx;
  logic [CW-1:0]   need, pushed, popped;
  logic [23:0]     fa;
  logic [22:0]     drop_addr;
  logic            pop, push;

  always_comb begin
    need     = inc_pc ? (CW'(fetch_sel) + CW'(1)) : CW'(1);
    mem_busy = pc_ld || (count < need);
    pop      = cen && inc_pc && !mem_busy;
    push     = cen && !pc_ld && (state == REQ) && bus_ok;
    pushed   = push ? (fa[0] ? CW'(1) : CW'(2)) : CW'(0);
    popped   = pop ? need : CW'(0);
    count_nx = count + pushed - popped;
    wr_ptr   = head + count[AW-1:0];
    bus_rd   = (state != IDLE);
    bus_addr = (state == DROP) ? drop_addr : fa[23:1];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (pc_ld || count <= CW'(QBYTES - 2)) state_nx = REQ;
      REQ: begin
        if (pc_ld)       state_nx = bus_ok ? REQ : DROP;
        else if (bus_ok) state_nx = (count_nx <= CW'(QBYTES - 2)) ? REQ : IDLE;
      end
      DROP: if (bus_ok) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pc        <= RST_PC;
      fa        <= RST_PC;
      count     <= '0;
      head      <= '0;
      drop_addr <= RST_PC[23:1];
    end else if (cen) begin
      state <= state_nx;
      if (pc_ld) begin
        pc    <= pc_din;
        fa    <= pc_din;
        count <= '0;
        // The abandoned read keeps its own address until the bus answers it.
        if (state == REQ && !bus_ok) drop_addr <= fa[23:1];
      end else begin
        count <= count_nx;
        if (pop) begin
          pc   <= pc + 24'(need);
          head <= head + AW'(need);
        end
        if (push) fa <= {fa[23:1] + 23'd1, 1'b0};
      end
    end
  end

  // Storage needs no reset: bytes beyond count are masked on read.
  always_ff @(posedge clk) begin
    if (push) begin
      if (fa[0]) begin
        queue[wr_ptr] <= bus_din[15:8];
      end else begin
        queue[wr_ptr]          <= bus_din[7:0];
        queue[wr_ptr + AW'(1)] <= bus_din[15:8];
      end
    end
  end

  always_comb begin
    md = '0;
    for (int i = 0; i < 4; i++) begin
      if (CW'(i) < count) md[8*i +: 8] = queue[head + AW'(i)];
    end
  end

`ifdef JT900H_FETCH_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cen) begin
      if (pc_ld)
        stall_cnt <= '0;
      else if (inc_pc && mem_busy && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_jt900h_fetch.sv
// ============================================================================
// tb_jt900h_fetch : randomized bench for jt900h_fetch with a byte-address model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jt900h_fetch;
  localparam int          QBYTES = 8;
  localparam logic [23:0] RST_PC = 24'hFF0000;

  logic        clk = 1'b0;
  logic        rst_n, cen, pc_ld, inc_pc, bus_ok, bus_rd, mem_busy;
  logic [23:0] pc_din, pc;
  logic [1:0]  fetch_sel;
  logic [31:0] md;
  logic [22:0] bus_addr;
  logic [15:0] bus_din;
`ifdef JT900H_FETCH_STATS_EN
  logic [15:0] stall_cnt;
`endif

  jt900h_fetch #(.QBYTES(QBYTES), .RST_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .pc_ld(pc_ld), .pc_din(pc_din),
    .inc_pc(inc_pc), .fetch_sel(fetch_sel), .md(md), .mem_busy(mem_busy),
    .pc(pc), .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_ok(bus_ok),
    .bus_din(bus_din)
`ifdef JT900H_FETCH_STATS_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference: the queue always holds the bytes at addresses pc .. pc+cnt-1.
  logic [23:0] m_pc, m_fa;
  int          m_cnt, m_stall, idle_run, age, lat;
  bit          m_stale;
  logic [22:0] m_stale_addr;
  logic [15:0] fixed_mem [logic [22:0]];

  function automatic logic [15:0] word_at(input logic [22:0] wa);
    if (fixed_mem.exists(wa)) return fixed_mem[wa];
    return wa[15:0] ^ {wa[22:16], wa[8:0]} ^ 16'h5A3C;
  endfunction

  function automatic logic [7:0] byte_at(input logic [23:0] a);
    logic [15:0] w;
    w = word_at(a[23:1]);
    return a[0] ? w[15:8] : w[7:0];
  endfunction

  task automatic model_reset();
    m_pc = RST_PC; m_fa = RST_PC; m_cnt = 0; m_stale = 0; m_stall = 0;
    idle_run = 0; age = 0;
  endtask

  task automatic check_and_update();
    int          need;
    bit          busy_e;
    logic [31:0] md_e;
    logic [23:0] a;
    need   = inc_pc ? int'(fetch_sel) + 1 : 1;
    busy_e = pc_ld || (m_cnt < need);
    md_e   = '0;
    for (int i = 0; i < 4; i++) begin
      a = m_pc + 24'(i);
      if (i < m_cnt) md_e[8*i +: 8] = byte_at(a);
    end
    chk("mem_busy", {31'd0, mem_busy}, {31'd0, busy_e});
    chk("md", md, md_e);
    chk("pc", {8'd0, pc}, {8'd0, m_pc});
    if (m_stale) begin
      chk("drop_rd", {31'd0, bus_rd}, 32'd1);
      chk("drop_addr", {9'd0, bus_addr}, {9'd0, m_stale_addr});
    end else if (m_cnt > QBYTES - 2) begin
      chk("full_rd", {31'd0, bus_rd}, 32'd0);
    end else if (bus_rd) begin
      chk("bus_addr", {9'd0, bus_addr}, {9'd0, m_fa[23:1]});
    end
    if (!m_stale && m_cnt <= QBYTES - 2 && cen && idle_run > 0)
      chk("idle_rd", {31'd0, bus_rd}, 32'd1);
`ifdef JT900H_FETCH_STATS_EN
    chk("stall_cnt", {16'd0, stall_cnt}, 32'(m_stall));
`endif
    if (bus_rd || (cen && m_cnt > QBYTES - 2)) idle_run = 0;
    else if (cen && !m_stale) idle_run++;

    if (cen) begin
      if (pc_ld) begin
        m_stall = 0;
        if (bus_rd && !bus_ok && !m_stale) m_stale_addr = m_fa[23:1];
        m_stale = bus_rd && !bus_ok;
        m_pc = pc_din; m_fa = pc_din; m_cnt = 0;
      end else begin
        if (inc_pc && busy_e && m_stall < 65535) m_stall++;
        if (inc_pc && !busy_e) begin
          m_pc  = m_pc + 24'(need);
          m_cnt = m_cnt - need;
        end
        if (bus_rd && bus_ok) begin
          if (m_stale) m_stale = 0;
          else begin
            m_cnt = m_cnt + (m_fa[0] ? 1 : 2);
            m_fa  = {m_fa[23:1] + 23'd1, 1'b0};
          end
        end
      end
    end
    if (cen && bus_ok) age = 0;
    else if (bus_rd) age++;
  endtask

  // Entered and left at posedge+1.
  task automatic cycle(input bit c, input bit ld, input logic [23:0] din,
                       input bit inc, input logic [1:0] fs);
    cen = c; pc_ld = ld; pc_din = din; inc_pc = inc; fetch_sel = fs;
    bus_ok  = bus_rd && (age >= lat);
    bus_din = !bus_ok ? 16'($urandom) : (m_stale ? 16'hDEAD : word_at(m_fa[23:1]));
    @(negedge clk);
    check_and_update();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycle(input int p_inc);
    logic [23:0] d;
    d = 24'($urandom);
    if (cen && bus_ok && age == 0) lat = $urandom_range(0, 3);
    cycle(($urandom % 100) < 85, ($urandom % 100) < 3, d,
          ($urandom % 100) < p_inc, 2'($urandom));
  endtask

  task automatic do_reset();
    cen = 0; pc_ld = 0; pc_din = 0; inc_pc = 0; fetch_sel = 0; bus_ok = 0; bus_din = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, mem_busy}, 32'd1);
    chk("rst_md", md, 32'd0);
    chk("rst_pc", {8'd0, pc}, {8'd0, RST_PC});
    chk("rst_rd", {31'd0, bus_rd}, 32'd0);
    chk("rst_addr", {9'd0, bus_addr}, {9'd0, RST_PC[23:1]});
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    fixed_mem[23'h7F8000] = 16'h2211;
    fixed_mem[23'h7F8001] = 16'h4433;
    fixed_mem[23'h00091A] = 16'hAABB;
    fixed_mem[23'h00091B] = 16'hDDCC;
    fixed_mem[23'h002000] = 16'h1234;
    fixed_mem[23'h002001] = 16'h5678;
    lat = 1;
    do_reset();

    // Reset fill with one-cycle bus latency.
    for (int k = 0; k < 30 && m_cnt < 4; k++) cycle(1, 0, 0, 0, 0);
    chk("fill_done", 32'(m_cnt >= 4), 32'd1);
    inc_pc = 1; fetch_sel = 3; cen = 0;
    #1;
    chk("fill_md", md, 32'h44332211);
    chk("fill_busy", {31'd0, mem_busy}, 32'd0);

    // Consume two bytes.
    cycle(1, 0, 0, 1, 1);
    chk("consume_pc", {8'd0, pc}, 32'h00FF0002);
    chk("consume_md", {16'd0, md[15:0]}, 32'h00004433);

    for (int k = 0; k < 1500; k++) rand_cycle((k / 250) % 2 ? 70 : 20);

    // Odd jump.
    lat = 1;
    cycle(1, 1, 24'h001235, 0, 0);
    for (int k = 0; k < 30 && m_cnt < 2; k++) cycle(1, 0, 0, 0, 0);
    chk("odd_done", 32'(m_cnt >= 2), 32'd1);
    chk("odd_md", {16'd0, md[15:0]}, 32'h0000CCAA);

    // Flush while a read is outstanding; the stale reply carries DEAD.
    lat = 3;
    for (int k = 0; k < 30 && !(bus_rd && age == 0); k++) cycle(1, 0, 0, 0, 0);
    chk("flush_pending", {31'd0, bus_rd}, 32'd1);
    cycle(1, 1, 24'h004000, 0, 0);
    for (int k = 0; k < 40 && m_cnt < 4; k++) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      chk("flush_md", 32'(md[8*i +: 8] == 8'hAD || md[8*i +: 8] == 8'hDE), 32'd0);

    // Stall on an empty queue with slow bus.
    lat = 5;
    cycle(1, 1, 24'h010000, 0, 0);
    for (int k = 0; k < 60 && m_cnt < 4; k++) cycle(1, 0, 0, 1, 3);
    cycle(1, 0, 0, 1, 3);
    chk("stall_pc", {8'd0, pc}, 32'h00010004);

    // Fill to full, then pop and freeze with cen low while bus answers.
    lat = 0;
    repeat (12) cycle(1, 0, 0, 0, 0);
    chk("full_idle", {31'd0, bus_rd}, 32'd0);
    cycle(1, 0, 0, 1, 3);
    cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    repeat (4) cycle(1, 0, 0, 0, 0);

    // Random phase with a reset while a read is pending.
    for (int k = 0; k < 2000; k++) begin
      rand_cycle((k / 200) % 2 ? 80 : 30);
      if (k == 1000) begin
        for (int j = 0; j < 30 && !bus_rd; j++) rand_cycle(30);
        chk("mid_pending", {31'd0, bus_rd}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        chk("mid_rst_rd", {31'd0, bus_rd}, 32'd0);
        chk("mid_rst_pc", {8'd0, pc}, {8'd0, RST_PC});
        lat = 1;
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
